// File: rtl/uart_mutex_nport.sv
// uart_mutex_nport
// Lets N MCU nodes share one UART peripheral driver. A node takes the lock with a prioritised
// start frame, or the host forces a particular node in through the IRQ override. While a node
// holds the lock, its bytes go to the driver and the driver's bytes come back tagged with that
// owner. The lock is released by a stop frame or by an idle watchdog, always through a one-cycle
// RELEASE state. Ties between equal priorities are broken round-robin.
module uart_mutex_nport #(
    parameter int          N_NODES  = 4,
    parameter logic [3:0]  FUNC_TAG = 4'hC,
    parameter logic [7:0]  IRQ_BYTE = 8'h4E,
    parameter int          TIMEOUT  = 1024,
    localparam int         IDX_W    = $clog2(N_NODES)
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic [16*N_NODES-1:0]  in_op,
    input  logic [7:0]             in_peripheral,
    input  logic                   in_irq_req,
    input  logic [IDX_W-1:0]       in_irq_node,
    output logic [7:0]             out_peripheral,
    output logic [15:0]            out_node,
    output logic                   periph_en,
    output logic [N_NODES-1:0]     out_irq,
    output logic                   lock_valid,
    output logic [IDX_W-1:0]       lock_owner
);

    localparam int          CNT_W    = $clog2(TIMEOUT);
    localparam logic [7:0]  FRAME_HI = {4'hF, FUNC_TAG};
    localparam logic [15:0] STOP_OP  = {4'hF, FUNC_TAG, 8'hFF};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        LOCKED  = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [IDX_W-1:0]   owner;
    logic [IDX_W-1:0]   next_owner;
    logic [IDX_W-1:0]   rr_ptr;
    logic [CNT_W-1:0]   idle_cnt;

    logic [15:0]        ops [N_NODES];
    logic [15:0]        owner_op;
    logic               owner_start;
    logic               owner_stop;
    logic               owner_idle;
    logic               timeout_hit;
    logic               irq_ok;

    logic               arb_valid;
    logic [IDX_W-1:0]   arb_node;
    logic [3:0]         arb_prio;
    int                 scan_idx;

    logic [7:0]         out_peripheral_n;
    logic [15:0]        out_node_n;
    logic               periph_en_n;
    logic [N_NODES-1:0] out_irq_n;
    logic               lock_valid_n;
    logic [IDX_W-1:0]   lock_owner_n;

    // A start frame carries the priority in its low nibble; priority 0 (0xFC00) is not a request.
    function automatic logic is_start(input logic [15:0] op);
        return (op[15:8] == FRAME_HI) && (op[7:4] == 4'h0) && (op[3:0] != 4'h0);
    endfunction

    // Split the flat op bus into one 16-bit op per node.
    always_comb begin
        for (int k = 0; k < N_NODES; k++) begin
            ops[k] = in_op[16*k +: 16];
        end
    end

    assign owner_op    = ops[owner];
    assign owner_start = is_start(owner_op);
    assign owner_stop  = (owner_op == STOP_OP);
    assign owner_idle  = (owner_op == 16'h0000);
    assign timeout_hit = (idle_cnt == CNT_W'(TIMEOUT - 1));
    assign irq_ok      = in_irq_req && (int'(in_irq_node) < N_NODES);

    // Pick the requester for the next lock. The scan starts at rr_ptr and only a strictly higher
    // priority displaces the current pick, so among equal priorities the first node at or after
    // rr_ptr wins.
    always_comb begin
        arb_valid = 1'b0;
        arb_node  = '0;
        arb_prio  = 4'h0;
        scan_idx  = 0;
        for (int i = 0; i < N_NODES; i++) begin
            scan_idx = int'(rr_ptr) + i;
            if (scan_idx >= N_NODES) begin
                scan_idx = scan_idx - N_NODES;
            end
            if (is_start(ops[scan_idx]) && (ops[scan_idx][3:0] > arb_prio)) begin
                arb_valid = 1'b1;
                arb_prio  = ops[scan_idx][3:0];
                arb_node  = IDX_W'(scan_idx);
            end
        end
    end

    // Hold the FSM state, owner, round-robin pointer and idle watchdog.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state    <= IDLE;
            owner    <= '0;
            rr_ptr   <= '0;
            idle_cnt <= '0;
        end else begin
            state <= next_state;
            owner <= next_owner;
            if (state == RELEASE) begin
                rr_ptr <= (int'(owner) == N_NODES - 1) ? '0 : owner + 1'b1;
            end
            if ((state == LOCKED) && owner_idle && (next_state == LOCKED)) begin
                idle_cnt <= idle_cnt + 1'b1;
            end else begin
                idle_cnt <= '0;
            end
        end
    end

    // Decide the next state and, in IDLE, which node is granted the lock.
    always_comb begin
        next_state = state;
        next_owner = owner;
        case (state)
            IDLE: begin
                if (irq_ok) begin
                    next_owner = in_irq_node;
                    next_state = ARM;
                end else if (arb_valid) begin
                    next_owner = arb_node;
                    next_state = ARM;
                end
            end
            ARM: begin
                next_state = LOCKED;
            end
            LOCKED: begin
                if (owner_stop || (owner_idle && timeout_hit)) begin
                    next_state = RELEASE;
                end
            end
            RELEASE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Work out next-cycle output values; data only flows while the lock stays held.
    always_comb begin
        out_peripheral_n = 8'h00;
        out_node_n       = 16'h0000;
        periph_en_n      = 1'b0;
        out_irq_n        = '0;
        lock_valid_n     = 1'b0;
        lock_owner_n     = '0;
        if ((next_state == ARM) || (next_state == LOCKED)) begin
            periph_en_n  = 1'b1;
            lock_valid_n = 1'b1;
            lock_owner_n = next_owner;
        end
        if ((state == LOCKED) && (next_state == LOCKED) && !owner_start) begin
            if (owner_idle) begin
                out_peripheral_n = out_peripheral;
                out_node_n       = out_node;
            end else begin
                out_peripheral_n = owner_op[7:0];
                out_node_n       = {8'h01 << owner, in_peripheral};
                out_irq_n        = {{(N_NODES-1){1'b0}}, (in_peripheral == IRQ_BYTE)} << owner;
            end
        end
    end

    // Register every output so the nodes and the driver see clean flop outputs.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            out_peripheral <= 8'h00;
            out_node       <= 16'h0000;
            periph_en      <= 1'b0;
            out_irq        <= '0;
            lock_valid     <= 1'b0;
            lock_owner     <= '0;
        end else begin
            out_peripheral <= out_peripheral_n;
            out_node       <= out_node_n;
            periph_en      <= periph_en_n;
            out_irq        <= out_irq_n;
            lock_valid     <= lock_valid_n;
            lock_owner     <= lock_owner_n;
        end
    end

endmodule

// File: tb/tb_uart_mutex_nport.sv
// tb_uart_mutex_nport
// Directed bench for the N-port UART mutex. Five nodes are used so that an out-of-range IRQ
// node index (5) can be expressed on the port, and a short watchdog keeps the timeout case brief.
module tb_uart_mutex_nport;

    localparam int N   = 5;
    localparam int TMO = 8;
    localparam int IW  = $clog2(N);

    logic            clk;
    logic            rst_n;
    logic [16*N-1:0] op_vec;
    logic [7:0]      per;
    logic            irq_req;
    logic [IW-1:0]   irq_node;
    logic [7:0]      out_peripheral;
    logic [15:0]     out_node;
    logic            periph_en;
    logic [N-1:0]    out_irq;
    logic            lock_valid;
    logic [IW-1:0]   lock_owner;

    int total;
    int bad;

    uart_mutex_nport #(
        .N_NODES  (N),
        .FUNC_TAG (4'hC),
        .IRQ_BYTE (8'h4E),
        .TIMEOUT  (TMO)
    ) dut (
        .CLK            (clk),
        .RST_N          (rst_n),
        .in_op          (op_vec),
        .in_peripheral  (per),
        .in_irq_req     (irq_req),
        .in_irq_node    (irq_node),
        .out_peripheral (out_peripheral),
        .out_node       (out_node),
        .periph_en      (periph_en),
        .out_irq        (out_irq),
        .lock_valid     (lock_valid),
        .lock_owner     (lock_owner)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Guard against a hung run.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before 100us");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int node, input logic [15:0] op);
        op_vec[16*node +: 16] = op;
    endtask

    task automatic clearInputs();
        op_vec   = '0;
        per      = 8'h00;
        irq_req  = 1'b0;
        irq_node = '0;
    endtask

    // Requests must already be on the bus; grants, then releases through a stop frame.
    task automatic grantAndRelease(input int exp_owner, input string tag);
        step();
        checkOutput({tag, "_owner"}, 32'(lock_owner), 32'(exp_owner));
        checkOutput({tag, "_valid"}, 32'(lock_valid), 32'd1);
        clearInputs();
        step();
        applyStimulus(exp_owner, 16'hFCFF);
        step();
        checkOutput({tag, "_release"}, 32'(lock_valid), 32'd0);
        clearInputs();
        step();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        clearInputs();
        rst_n = 1'b0;
        step();
        step();
        checkOutput("rst_periph",   32'(out_peripheral), 32'h0);
        checkOutput("rst_node",     32'(out_node),       32'h0);
        checkOutput("rst_irq",      32'(out_irq),        32'h0);
        checkOutput("rst_en",       32'(periph_en),      32'h0);
        checkOutput("rst_valid",    32'(lock_valid),     32'h0);
        checkOutput("rst_owner",    32'(lock_owner),     32'h0);
        rst_n = 1'b1;
        step();
        checkOutput("idle_valid",   32'(lock_valid),     32'h0);

        // Single request from node 2, then owner traffic.
        applyStimulus(2, 16'hFC05);
        step();
        checkOutput("arm_valid",    32'(lock_valid),     32'h1);
        checkOutput("arm_en",       32'(periph_en),      32'h1);
        checkOutput("arm_owner",    32'(lock_owner),     32'h2);
        checkOutput("arm_data",     32'(out_peripheral), 32'h0);
        clearInputs();
        applyStimulus(2, 16'h0041);
        per = 8'h33;
        step();
        checkOutput("lock1_data",   32'(out_peripheral), 32'h0);
        step();
        checkOutput("fwd_periph",   32'(out_peripheral), 32'h41);
        checkOutput("fwd_node",     32'(out_node),       32'h0433);
        checkOutput("fwd_en",       32'(periph_en),      32'h1);
        checkOutput("fwd_irq",      32'(out_irq),        32'h0);
        applyStimulus(2, 16'h0010);
        per = 8'h4E;
        step();
        checkOutput("irq_set",      32'(out_irq),        32'h04);
        checkOutput("irq_periph",   32'(out_peripheral), 32'h10);
        checkOutput("irq_node",     32'(out_node),       32'h044E);
        applyStimulus(2, 16'h0000);
        per = 8'h99;
        step();
        checkOutput("hold_irq",     32'(out_irq),        32'h0);
        checkOutput("hold_periph",  32'(out_peripheral), 32'h10);
        checkOutput("hold_node",    32'(out_node),       32'h044E);
        applyStimulus(0, 16'hFCFF);
        applyStimulus(2, 16'h0022);
        per = 8'h01;
        step();
        checkOutput("foreign_stop", 32'(lock_valid),     32'h1);
        checkOutput("fs_periph",    32'(out_peripheral), 32'h22);
        checkOutput("fs_node",      32'(out_node),       32'h0401);
        applyStimulus(0, 16'h0000);
        applyStimulus(2, 16'hFC03);
        step();
        checkOutput("start_periph", 32'(out_peripheral), 32'h0);
        checkOutput("start_node",   32'(out_node),       32'h0);
        checkOutput("start_valid",  32'(lock_valid),     32'h1);
        applyStimulus(2, 16'hFCFF);
        step();
        checkOutput("rel_valid",    32'(lock_valid),     32'h0);
        checkOutput("rel_en",       32'(periph_en),      32'h0);
        checkOutput("rel_owner",    32'(lock_owner),     32'h0);
        checkOutput("rel_node",     32'(out_node),       32'h0);
        clearInputs();
        step();
        checkOutput("post_idle",    32'(lock_valid),     32'h0);

        // Priority and round-robin tie-break (rr_ptr is 3 here).
        applyStimulus(0, 16'hFC07);
        applyStimulus(3, 16'hFC09);
        grantAndRelease(3, "prio");
        applyStimulus(1, 16'hFC04);
        applyStimulus(3, 16'hFC04);
        grantAndRelease(1, "rr_wrap");
        applyStimulus(1, 16'hFC04);
        applyStimulus(3, 16'hFC04);
        grantAndRelease(3, "rr_ptr2");
        applyStimulus(1, 16'hFC04);
        applyStimulus(3, 16'hFC04);
        grantAndRelease(1, "rr_again");
        applyStimulus(4, 16'hFC01);
        grantAndRelease(4, "node4");
        applyStimulus(0, 16'hFC02);
        applyStimulus(4, 16'hFC02);
        grantAndRelease(0, "rr_zero");
        applyStimulus(1, 16'hFC03);
        applyStimulus(2, 16'hFC08);
        grantAndRelease(2, "prio_over_rr");

        // IRQ override, valid and out-of-range node index.
        irq_req  = 1'b1;
        irq_node = 3'd1;
        applyStimulus(0, 16'hFC0F);
        grantAndRelease(1, "irq");
        irq_req  = 1'b1;
        irq_node = 3'd5;
        applyStimulus(0, 16'hFC0F);
        grantAndRelease(0, "irq_bad");

        // Priority-0 frames are not requests.
        for (int k = 0; k < N; k++) applyStimulus(k, 16'hFC00);
        step();
        step();
        checkOutput("fc00_idle",    32'(lock_valid),     32'h0);
        clearInputs();

        // Idle watchdog with a foreign stop frame in the middle.
        applyStimulus(2, 16'hFC05);
        step();
        checkOutput("tmo_owner",    32'(lock_owner),     32'h2);
        clearInputs();
        step();
        for (int i = 1; i < TMO; i++) begin
            if (i == 3) applyStimulus(0, 16'hFCFF);
            if (i == 5) applyStimulus(0, 16'h0000);
            step();
            checkOutput("tmo_held",  32'(lock_valid),     32'h1);
        end
        step();
        checkOutput("tmo_valid",    32'(lock_valid),     32'h0);
        checkOutput("tmo_en",       32'(periph_en),      32'h0);
        applyStimulus(1, 16'hFC01);
        step();
        checkOutput("rel_nosample", 32'(lock_valid),     32'h0);
        step();
        checkOutput("relock_owner", 32'(lock_owner),     32'h1);
        clearInputs();
        applyStimulus(1, 16'h0041);
        per = 8'h55;
        step();
        step();
        checkOutput("n1_periph",    32'(out_peripheral), 32'h41);
        checkOutput("n1_node",      32'(out_node),       32'h0255);

        // Reset while locked.
        rst_n = 1'b0;
        step();
        checkOutput("mrst_periph",  32'(out_peripheral), 32'h0);
        checkOutput("mrst_node",    32'(out_node),       32'h0);
        checkOutput("mrst_valid",   32'(lock_valid),     32'h0);
        checkOutput("mrst_en",      32'(periph_en),      32'h0);
        rst_n = 1'b1;
        clearInputs();
        for (int k = 0; k < N; k++) applyStimulus(k, 16'hFC00);
        step();
        step();
        checkOutput("mrst_idle",    32'(lock_valid),     32'h0);
        checkOutput("mrst_idle_en", 32'(periph_en),      32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
